// File: rtl/sprite_pkg.sv
// Shared constants, register map and FSM state type for the sprite DMA.
// No logic here; imported by cfg_regs and sprite_dma.
package sprite_pkg;
    localparam int SPR_NBYTES = 10;

    localparam logic [1:0] REG_BASE_LO = 2'd0;
    localparam logic [1:0] REG_BASE_HI = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_START_BIT   = 1;
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_OVERRUN_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        CAP,
        WRITE,
        FIN
    } dma_state_t;
endpackage

// File: rtl/sprite_dma_cfg_regs.sv
// CPU register file: BASE, CTRL.ENABLE, STATUS.OVERRUN, registered read data.
// Writes take effect at the next edge, reads return on the next edge; START is a same-cycle pulse.
// No backpressure: the CPU port is always ready.
module cfg_regs
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_cs,
    input  logic        cfg_rw,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_di,
    output logic [7:0]  cfg_do,
    input  logic        busy,
    input  logic        overrun_set,
    output logic [15:0] base,
    output logic        enable,
    output logic        start
);
    logic       wr_en;
    logic       rd_en;
    logic       overrun;
    logic       overrun_clr;
    logic [7:0] rd_dat;

    assign wr_en       = cfg_cs & cfg_rw;
    assign rd_en       = cfg_cs & ~cfg_rw;
    assign start       = wr_en && (cfg_addr == REG_CTRL) && cfg_di[CTRL_START_BIT];
    assign overrun_clr = wr_en && (cfg_addr == REG_STATUS) && cfg_di[STAT_OVERRUN_BIT];

    always_comb begin
        rd_dat = 8'h00;
        case (cfg_addr)
            REG_BASE_LO: rd_dat = base[7:0];
            REG_BASE_HI: rd_dat = base[15:8];
            REG_CTRL:    rd_dat[CTRL_ENABLE_BIT] = enable;
            default: begin
                rd_dat[STAT_BUSY_BIT]    = busy;
                rd_dat[STAT_OVERRUN_BIT] = overrun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base    <= 16'h0000;
            enable  <= 1'b0;
            overrun <= 1'b0;
            cfg_do  <= 8'h00;
        end else begin
            if (wr_en && cfg_addr == REG_BASE_LO) base[7:0]  <= cfg_di;
            if (wr_en && cfg_addr == REG_BASE_HI) base[15:8] <= cfg_di;
            if (wr_en && cfg_addr == REG_CTRL)    enable     <= cfg_di[CTRL_ENABLE_BIT];
            // a set in the same cycle as a clear must not be lost
            if (overrun_set)      overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
            if (rd_en) cfg_do <= rd_dat;
        end
    end
endmodule

// File: rtl/sprite_dma.sv
// Copies an NBYTES sprite record from main memory into the sprite register file once per trigger.
// 3 cycles per byte with grant held; done 1+3*NBYTES+1 cycles after the trigger edge.
// Grant loss stalls between bytes and resumes at the same index; triggers while busy set OVERRUN.
module sprite_dma
    import sprite_pkg::*;
#(
    parameter int NBYTES = SPR_NBYTES,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          cfg_cs,
    input  logic          cfg_rw,
    input  logic [1:0]    cfg_addr,
    input  logic [7:0]    cfg_di,
    output logic [7:0]    cfg_do,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_di,
    output logic          spr_cs,
    output logic          spr_rw,
    output logic [3:0]    spr_addr,
    output logic [7:0]    spr_do,
    output logic          busy,
    output logic          done
);
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    dma_state_t    state, state_nxt;
    logic          vsync_q;
    logic          trigger;
    logic          start;
    logic          enable;
    logic [15:0]   base;
    logic [AW-1:0] base_q;
    logic [3:0]    idx;
    logic [7:0]    data_q;

    cfg_regs u_cfg_regs (
        .clk         (clk),
        .reset       (reset),
        .cfg_cs      (cfg_cs),
        .cfg_rw      (cfg_rw),
        .cfg_addr    (cfg_addr),
        .cfg_di      (cfg_di),
        .cfg_do      (cfg_do),
        .busy        (busy),
        .overrun_set (trigger & busy),
        .base        (base),
        .enable      (enable),
        .start       (start)
    );

    // START and a vsync edge in the same cycle merge into one trigger
    assign trigger = (vsync & ~vsync_q & enable) | start;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (trigger) state_nxt = REQ;
            REQ:   if (bus_gnt) state_nxt = READ;
            READ:  state_nxt = CAP;
            CAP:   state_nxt = WRITE;
            WRITE: begin
                if (idx == LAST_IDX) state_nxt = FIN;
                else if (bus_gnt)    state_nxt = READ;
                else                 state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req  = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        spr_cs   = 1'b0;
        spr_rw   = 1'b0;
        spr_addr = 4'h0;
        spr_do   = 8'h00;
        done     = 1'b0;
        case (state)
            REQ:  bus_req = 1'b1;
            READ: begin
                bus_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = base_q + AW'(idx);
            end
            CAP:  bus_req = 1'b1;
            WRITE: begin
                bus_req  = 1'b1;
                spr_cs   = 1'b1;
                spr_rw   = 1'b1;
                spr_addr = idx;
                spr_do   = data_q;
            end
            FIN:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            base_q  <= '0;
            idx     <= 4'h0;
            data_q  <= 8'h00;
        end else begin
            vsync_q <= vsync;
            if (state == IDLE && trigger) begin
                idx    <= 4'h0;
                base_q <= AW'(base);
            end
            if (state == CAP) data_q <= mem_di;
            if (state == WRITE && idx != LAST_IDX) idx <= idx + 4'h1;
        end
    end
endmodule

// File: tb/tb_sprite_dma.sv
// Randomized bench for sprite_dma against a RAM model and a per-byte expectation of the copy.
module tb_sprite_dma;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        cfg_cs = 1'b0, cfg_rw = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_di = 8'h00;
    logic [7:0]  cfg_do;
    logic        bus_req, bus_gnt = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di = 8'h00;
    logic        spr_cs, spr_rw;
    logic [3:0]  spr_addr;
    logic [7:0]  spr_do;
    logic        busy, done;

    logic [7:0]  mem [0:65535];
    int          n_chk = 0, n_err = 0;
    int          tot_rd = 0, tot_wr = 0, rd0 = 0, wr0 = 0;
    logic [15:0] m_base = 16'h0000;
    logic        gnt_s = 1'b1;

    sprite_dma #(.NBYTES(10), .AW(16)) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .cfg_cs(cfg_cs), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr), .cfg_di(cfg_di), .cfg_do(cfg_do),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_di(mem_di),
        .spr_cs(spr_cs), .spr_rw(spr_rw), .spr_addr(spr_addr), .spr_do(spr_do),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RAM answers one cycle after the read strobe
    always @(posedge clk) begin
        gnt_s <= bus_gnt;
        if (mem_rd) mem_di <= mem[mem_addr];
    end

    // Byte i of a copy must be read from base+i (mod 2^16) and land at sprite register i
    always @(negedge clk) begin : monitor
        logic [15:0] ea;
        int n;
        if (!reset) begin
            if (mem_rd) begin
                ea = m_base + 16'(tot_rd - rd0);
                check_val("rd_addr", {16'h0, mem_addr}, {16'h0, ea});
                check_val("rd_after_gnt", {31'h0, gnt_s}, 32'd1);
                tot_rd++;
            end
            if (spr_cs) begin
                n = tot_wr - wr0;
                check_val("wr_in_range", {31'h0, n < 10}, 32'd1);
                if (n < 10) begin
                    ea = m_base + 16'(n);
                    check_val("wr_rw", {31'h0, spr_rw}, 32'd1);
                    check_val("wr_addr", {28'h0, spr_addr}, n);
                    check_val("wr_data", {24'h0, spr_do}, {24'h0, mem[ea]});
                end
                tot_wr++;
            end
        end
    end

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        cfg_cs = 1'b1; cfg_rw = 1'b1; cfg_addr = a; cfg_di = d;
        @(negedge clk);
        cfg_cs = 1'b0; cfg_rw = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [7:0] d);
        cfg_cs = 1'b1; cfg_rw = 1'b0; cfg_addr = a;
        @(negedge clk);
        d = cfg_do;
        cfg_cs = 1'b0;
    endtask

    task automatic set_base(input logic [15:0] b);
        cfg_wr(REG_BASE_LO, b[7:0]);
        cfg_wr(REG_BASE_HI, b[15:8]);
    endtask

    task automatic arm(input logic [15:0] b);
        m_base = b; rd0 = tot_rd; wr0 = tot_wr;
    endtask

    // mode 0: grant held, 1: random grant, 2: scripted stalls, 3: START/STATUS traffic mid-copy
    task automatic wait_done(input int mode, output int cyc);
        int  wseen = 0, stall = 0;
        bit  seen = 0;
        int  k;
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (spr_cs) wseen++;
            if (done) begin seen = 1; break; end
            case (mode)
                1: bus_gnt = ($urandom_range(0, 3) != 0);
                2: begin
                    if (k == 3) check_val("stall_req_no_rd", {30'h0, bus_req, mem_rd}, 32'd2);
                    if (k == 5) bus_gnt = 1'b1;
                    if (wseen == 4 && stall == 0) begin bus_gnt = 1'b0; stall = 1; end
                    else if (stall > 0 && stall < 4) stall++;
                    else if (stall == 4) begin bus_gnt = 1'b1; stall = 5; end
                end
                3: begin
                    case (k)
                        8:  begin cfg_cs = 1; cfg_rw = 1; cfg_addr = REG_CTRL; cfg_di = 8'h03; end
                        10: begin cfg_cs = 1; cfg_rw = 0; cfg_addr = REG_STATUS; end
                        11: begin check_val("status_overrun", {24'h0, cfg_do}, 32'h03); cfg_cs = 0; end
                        12: begin cfg_cs = 1; cfg_rw = 1; cfg_addr = REG_STATUS; cfg_di = 8'h02; end
                        14: begin cfg_cs = 1; cfg_rw = 0; cfg_addr = REG_STATUS; end
                        15: begin check_val("status_cleared", {24'h0, cfg_do}, 32'h01); cfg_cs = 0; end
                        default: begin cfg_cs = 0; cfg_rw = 0; end
                    endcase
                end
                default: ;
            endcase
        end
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
        bus_gnt = 1'b1;
        cyc = k;
    endtask

    task automatic post();
        @(negedge clk);
        check_val("req_low_after", {31'h0, bus_req}, 32'd0);
        check_val("idle_after", {31'h0, busy}, 32'd0);
        check_val("n_writes", tot_wr - wr0, 32'd10);
        check_val("n_reads", tot_rd - rd0, 32'd10);
        vsync = 1'b0;
    endtask

    initial begin : main
        int c, ir, ic;
        logic [7:0] d;
        logic [15:0] b;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        #1;
        check_val("rst_bus_req", {31'h0, bus_req}, 32'd0);
        check_val("rst_spr_cs", {31'h0, spr_cs}, 32'd0);
        check_val("rst_busy_done", {30'h0, busy, done}, 32'd0);
        check_val("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        check_val("rst_cfg_do", {24'h0, cfg_do}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cfg_rd(REG_BASE_HI, d); check_val("rst_base_hi", {24'h0, d}, 32'd0);
        cfg_rd(REG_CTRL, d);    check_val("rst_ctrl", {24'h0, d}, 32'd0);
        cfg_rd(REG_STATUS, d);  check_val("rst_status", {24'h0, d}, 32'd0);

        // basic copy
        for (int i = 0; i < 10; i++) mem[16'h1200 + i] = 8'hA0 + 8'(i);
        set_base(16'h1200);
        cfg_wr(REG_CTRL, 8'h01);
        cfg_rd(REG_BASE_LO, d); check_val("base_lo_rb", {24'h0, d}, 32'h00);
        cfg_rd(REG_BASE_HI, d); check_val("base_hi_rb", {24'h0, d}, 32'h12);
        arm(16'h1200); bus_gnt = 1'b1; vsync = 1'b1;
        wait_done(0, c); check_val("done_cycle", c, 32'd32);
        post();

        // grant stalls
        b = 16'($urandom);
        set_base(b); arm(b); bus_gnt = 1'b0; vsync = 1'b1;
        wait_done(2, c); post();

        // overrun via START mid-copy
        set_base(16'h4000); arm(16'h4000); vsync = 1'b1;
        wait_done(3, c); check_val("overrun_done_cycle", c, 32'd32);
        post();

        // address wrap
        set_base(16'hFFFC); arm(16'hFFFC); vsync = 1'b1;
        wait_done(0, c); post();

        // START and vsync edge together: one copy, no overrun
        set_base(16'h0100); arm(16'h0100); vsync = 1'b1;
        cfg_wr(REG_CTRL, 8'h03);
        wait_done(0, c); check_val("merged_done_cycle", c, 32'd31);
        post();
        cfg_rd(REG_STATUS, d); check_val("merged_no_overrun", {24'h0, d}, 32'h00);

        // trigger in FIN cycle is dropped and flags overrun
        arm(16'h0100); vsync = 1'b1;
        wait_done(0, c);
        cfg_wr(REG_CTRL, 8'h03);
        check_val("fin_trigger_dropped", {30'h0, busy, bus_req}, 32'd0);
        check_val("fin_n_writes", tot_wr - wr0, 32'd10);
        vsync = 1'b0;
        cfg_rd(REG_STATUS, d); check_val("fin_overrun", {24'h0, d}, 32'h02);
        cfg_wr(REG_STATUS, 8'h02);
        cfg_rd(REG_STATUS, d); check_val("fin_overrun_clr", {24'h0, d}, 32'h00);

        // randomized copies with a random grant
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom);
            set_base(b); arm(b);
            bus_gnt = 1'($urandom_range(0, 1)); vsync = 1'b1;
            wait_done(1, c); post();
        end

        // reset during byte 6
        set_base(16'h2000); arm(16'h2000); vsync = 1'b1;
        ic = 0;
        for (int k = 0; k < 100 && ic < 6; k++) begin
            @(negedge clk);
            if (spr_cs) ic++;
        end
        check_val("reached_byte6", ic, 32'd6);
        #2 reset = 1'b1;
        #1;
        check_val("rstmid_outs", {29'h0, bus_req, spr_cs, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0; vsync = 1'b0;
        ic = tot_wr; ir = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_req) ir++;
        end
        check_val("rstmid_no_req", ir, 32'd0);
        check_val("rstmid_no_writes", tot_wr - ic, 32'd0);
        cfg_rd(REG_CTRL, d); check_val("rstmid_ctrl", {24'h0, d}, 32'd0);

        // disabled: vsync edges ignored, START still copies
        set_base(16'h3400);
        ir = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            vsync = (k % 8) < 4;
            if (bus_req) ir++;
        end
        vsync = 1'b0;
        @(negedge clk); if (bus_req) ir++;
        check_val("disabled_no_req", ir, 32'd0);
        arm(16'h3400);
        cfg_wr(REG_CTRL, 8'h02);
        wait_done(0, c); check_val("start_done_cycle", c, 32'd31);
        post();
        cfg_rd(REG_CTRL, d); check_val("start_not_stored", {24'h0, d}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule
